filter_arbiter: RTL
===================

FILTER_ARBITER -- requirements
Module: filter_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_FILTER, 4, number of filter buffers sharing one force pipeline.
- DATA_WIDTH, 32, entry width.
- FILTER_BUFFER_ADDR_WIDTH, 5, usedw width (depth 32).
- BACK_PRESSURE_THRESHOLD, 28, usedw level that stalls a filter.
- SEL_WIDTH, 2, log2(NUM_FILTER).

REQ-002 Ports (name, direction, width, meaning); one clock; reset is synchronous and active-high:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- buffer_empty  in  NUM_FILTER  per-buffer empty flag.
- buffer_full  in  NUM_FILTER  per-buffer full flag.
- buffer_usedw  in  NUM_FILTER*FILTER_BUFFER_ADDR_WIDTH  per-buffer fill level; buffer i occupies slice i.
- buffer_q  in  NUM_FILTER*DATA_WIDTH  per-buffer read data; valid the cycle after rdreq.
- pipeline_back_pressure  in  1  downstream pipeline cannot accept new issues.
- buffer_rdreq  out  NUM_FILTER  one-hot read strobe.
- filter_back_pressure  out  NUM_FILTER  per-filter stall request.
- out_data  out  DATA_WIDTH  arbitrated entry.
- out_valid  out  1  out_data qualifier.
- out_sel  out  SEL_WIDTH  source buffer index of out_data.

Function
REQ-003 Arbitration: each cycle, search from rr_ptr upward, modulo NUM_FILTER, for the first i with buffer_empty[i]=0.
REQ-004 buffer_rdreq is combinational from rr_ptr, buffer_empty and pipeline_back_pressure.
REQ-005 At most one rdreq bit is high per cycle, and never for an empty buffer.
REQ-006 No rdreq is issued in any cycle where pipeline_back_pressure=1; rr_ptr holds during that cycle.
REQ-007 On grant of index g, rr_ptr <= (g+1) mod NUM_FILTER; with no grant, rr_ptr holds.
REQ-008 A single non-empty buffer may be granted on consecutive cycles.
REQ-009 Read pipeline:
- Stage 1 registers grant_valid and grant_sel at the rdreq edge.
- Stage 2 captures buffer_q[grant_sel] into out_data, asserts out_valid, sets out_sel=grant_sel.
- Total latency rdreq cycle -> out_valid is 2 cycles.
REQ-010 Throughput is one entry per cycle sustained; in-flight entries are never dropped when pipeline_back_pressure rises.
- Downstream tolerates 2 trailing entries.
REQ-011 out_valid=0 on cycles without a matching stage-1 grant; out_data and out_sel then hold their last value.
REQ-012 filter_back_pressure[i] is registered: = buffer_full[i] OR (buffer_usedw[i] >= BACK_PRESSURE_THRESHOLD).
- buffer_full covers usedw wrapping to 0 at depth 32.
REQ-013 Boundary cases:
- All buffers empty: no rdreq, rr_ptr holds.
- rr_ptr wraps from NUM_FILTER-1 to 0.
- usedw=27 gives no stall; usedw=28 gives a stall.
- usedw=0 with full=1 gives a stall.

Reset
REQ-014 While rst=1, at the clock edge:
- rr_ptr=0, stage-1 valid=0.
- out_valid=0, out_data=0, out_sel=0.
- filter_back_pressure=0.
- buffer_rdreq is forced to 0 combinationally.
REQ-015 Reset mid-operation discards all in-flight grants; no out_valid occurs for reads issued before reset.
REQ-016 The first grant after release starts the search at index 0.

Structure
REQ-017 Shared package holds NUM_FILTER, DATA_WIDTH, FILTER_BUFFER_ADDR_WIDTH, SEL_WIDTH and BACK_PRESSURE_THRESHOLD.
REQ-018 Sub-module rr_priority_select is combinational: rotate by rr_ptr, priority-encode, un-rotate; outputs grant_valid and grant_sel.
REQ-019 filter_arbiter instantiates rr_priority_select once, plus the pointer, two pipeline stages and the back-pressure registers.

Verification
REQ-020 Bench drives buffer models with scfifo normal-mode timing (1-cycle read latency) and covers:
- All 4 buffers hold 3 entries (0xA0+k, 0xB0+k, 0xC0+k, 0xD0+k) -> out_sel sequence 0,1,2,3,0,1,2,3,0,1,2,3, out_valid continuous for 12 cycles, first out_valid 2 cycles after first rdreq.
- Only buffer 2 non-empty with 5 entries -> 5 consecutive rdreq[2]; all out_sel=2; no rdreq after empty rises.
- pipeline_back_pressure high for 4 cycles mid-stream -> rdreq=0 those cycles; at most 2 trailing out_valid; rr_ptr resumes at the next index; no entry lost or duplicated.
- buffer_usedw[1] stepped 27 -> 28, then full=1 with usedw=0 -> filter_back_pressure[1] goes 0 -> 1 one cycle after 28 and stays 1 while full.
- rst asserted one cycle after a grant to buffer 3 -> out_valid=0 after reset; next grant goes to the lowest non-empty index.
- All buffers empty for 10 cycles -> buffer_rdreq=0, out_valid=0, rr_ptr unchanged.

Source files
------------

// File: rtl/filter_arbiter_pkg.sv
// Shared sizing constants for the filter arbiter and its round-robin selector.
package filter_arbiter_pkg;

    localparam int NUM_FILTER               = 4;
    localparam int DATA_WIDTH               = 32;
    localparam int FILTER_BUFFER_ADDR_WIDTH = 5;
    localparam int BACK_PRESSURE_THRESHOLD  = 28;
    localparam int SEL_WIDTH                = 2;

endpackage

// File: rtl/filter_arbiter_rr_priority_select.sv
// Combinational round-robin selector: rotate the request vector so rr_ptr sits
// at bit 0, pick the lowest set bit, then map that index back to buffer space.
module rr_priority_select
    import filter_arbiter_pkg::*;
#(
    parameter int NUM_FILTER = filter_arbiter_pkg::NUM_FILTER,
    parameter int SEL_WIDTH  = filter_arbiter_pkg::SEL_WIDTH
) (
    input  logic [NUM_FILTER-1:0] req,
    input  logic [SEL_WIDTH-1:0]  rr_ptr,
    output logic                  grant_valid,
    output logic [SEL_WIDTH-1:0]  grant_sel
);

    logic [2*NUM_FILTER-1:0] doubled;
    logic [NUM_FILTER-1:0]   rotated;
    logic [SEL_WIDTH-1:0]    rot_idx;
    logic [SEL_WIDTH:0]      idx_sum;

    // Rotate right by rr_ptr so the highest-priority requester lands on bit 0.
    always_comb begin
        doubled = {req, req} >> rr_ptr;
        rotated = doubled[NUM_FILTER-1:0];
    end

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        grant_valid = 1'b0;
        rot_idx     = '0;
        for (int i = NUM_FILTER - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                grant_valid = 1'b1;
                rot_idx     = SEL_WIDTH'(i);
            end
        end
    end

    // Undo the rotation: add rr_ptr back, wrapping at NUM_FILTER.
    always_comb begin
        idx_sum = {1'b0, rot_idx} + {1'b0, rr_ptr};
        if (idx_sum >= (SEL_WIDTH + 1)'(NUM_FILTER)) begin
            idx_sum = idx_sum - (SEL_WIDTH + 1)'(NUM_FILTER);
        end
        grant_sel = idx_sum[SEL_WIDTH-1:0];
    end

endmodule

// File: rtl/filter_arbiter.sv
// Round-robin arbiter draining several filter FIFOs into one pipeline, with a
// two-stage read path and registered per-filter back-pressure.
module filter_arbiter
    import filter_arbiter_pkg::*;
#(
    parameter int NUM_FILTER               = filter_arbiter_pkg::NUM_FILTER,
    parameter int DATA_WIDTH               = filter_arbiter_pkg::DATA_WIDTH,
    parameter int FILTER_BUFFER_ADDR_WIDTH = filter_arbiter_pkg::FILTER_BUFFER_ADDR_WIDTH,
    parameter int BACK_PRESSURE_THRESHOLD  = filter_arbiter_pkg::BACK_PRESSURE_THRESHOLD,
    parameter int SEL_WIDTH                = filter_arbiter_pkg::SEL_WIDTH
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NUM_FILTER-1:0]                        buffer_empty,
    input  logic [NUM_FILTER-1:0]                        buffer_full,
    input  logic [NUM_FILTER*FILTER_BUFFER_ADDR_WIDTH-1:0] buffer_usedw,
    input  logic [NUM_FILTER*DATA_WIDTH-1:0]             buffer_q,
    input  logic                                         pipeline_back_pressure,
    output logic [NUM_FILTER-1:0]                        buffer_rdreq,
    output logic [NUM_FILTER-1:0]                        filter_back_pressure,
    output logic [DATA_WIDTH-1:0]                        out_data,
    output logic                                         out_valid,
    output logic [SEL_WIDTH-1:0]                         out_sel
);

    logic [NUM_FILTER-1:0] req;
    logic [SEL_WIDTH-1:0]  rr_ptr;
    logic [SEL_WIDTH-1:0]  next_ptr;
    logic                  grant_valid;
    logic [SEL_WIDTH-1:0]  grant_sel;
    logic                  grant_en;
    logic                  s1_valid;
    logic [SEL_WIDTH-1:0]  s1_sel;
    logic [DATA_WIDTH-1:0] sel_data;

    assign req = ~buffer_empty;

    rr_priority_select #(
        .NUM_FILTER (NUM_FILTER),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_select (
        .req         (req),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel)
    );

    // Issue a one-hot read only when downstream can accept and we are not in reset.
    always_comb begin
        grant_en     = grant_valid && !pipeline_back_pressure && !rst;
        buffer_rdreq = '0;
        if (grant_en) begin
            buffer_rdreq[grant_sel] = 1'b1;
        end
    end

    // Pointer moves to the slot just past the winner, wrapping at NUM_FILTER.
    always_comb begin
        if (grant_sel == SEL_WIDTH'(NUM_FILTER - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_sel + 1'b1;
        end
    end

    // Round-robin pointer register; holds whenever nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_en) begin
            rr_ptr <= next_ptr;
        end
    end

    // Stage 1 remembers which buffer was read while its data is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sel   <= '0;
        end else begin
            s1_valid <= grant_en;
            if (grant_en) begin
                s1_sel <= grant_sel;
            end
        end
    end

    // Pick the read data of the buffer that stage 1 points at.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_FILTER; i++) begin
            if (s1_sel == SEL_WIDTH'(i)) begin
                sel_data = buffer_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Stage 2 presents the entry; data and source hold between valid beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= sel_data;
                out_sel  <= s1_sel;
            end
        end
    end

    // Stall a filter when its buffer is full or filled past the threshold.
    always_ff @(posedge clk) begin
        if (rst) begin
            filter_back_pressure <= '0;
        end else begin
            for (int i = 0; i < NUM_FILTER; i++) begin
                filter_back_pressure[i] <= buffer_full[i] ||
                    (buffer_usedw[i*FILTER_BUFFER_ADDR_WIDTH +: FILTER_BUFFER_ADDR_WIDTH]
                        >= FILTER_BUFFER_ADDR_WIDTH'(BACK_PRESSURE_THRESHOLD));
            end
        end
    end

endmodule
